// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath over 2-5 states per
// instruction and stalls IF/MR/MW on the memory-ready handshake.
module mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      Opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            ExtOp,
  output logic [1:0]      PCSource,
  output logic            instr_done,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
  localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
  localparam logic [ST_W-1:0] S_MA  = ST_W'(2);
  localparam logic [ST_W-1:0] S_MR  = ST_W'(3);
  localparam logic [ST_W-1:0] S_MW  = ST_W'(4);
  localparam logic [ST_W-1:0] S_WBL = ST_W'(5);
  localparam logic [ST_W-1:0] S_EXR = ST_W'(6);
  localparam logic [ST_W-1:0] S_WBR = ST_W'(7);
  localparam logic [ST_W-1:0] S_EXI = ST_W'(8);
  localparam logic [ST_W-1:0] S_WBI = ST_W'(9);
  localparam logic [ST_W-1:0] S_BR  = ST_W'(10);
  localparam logic [ST_W-1:0] S_JMP = ST_W'(11);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADDU = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [ST_W-1:0] state_q, state_d;
  logic            illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        case (Opcode)
          OP_R:                              state_d = S_EXR;
          OP_ADDI, OP_ADDU, OP_ORI, OP_LUI:  state_d = S_EXI;
          OP_LW, OP_SW:                      state_d = S_MA;
          OP_BEQ:                            state_d = S_BR;
          OP_J:                              state_d = S_JMP;
          default: begin
            state_d   = S_IF;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MA:  state_d = (Opcode == OP_LW) ? S_MR : S_MW;
      S_MR:  if (mem_ready) state_d = S_WBL;
      S_MW:  if (mem_ready) state_d = S_IF;
      S_EXR: state_d = S_WBR;
      S_EXI: state_d = S_WBI;
      default: state_d = S_IF;
    endcase
  end

  // Moore decode; reset overrides everything so no enable leaks during rst.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    ExtOp       = 1'b0;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 3'b010;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          ALUOp   = 3'b010;
          ExtOp   = 1'b1;
        end
        S_MA: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 3'b010;
          ExtOp   = 1'b1;
        end
        S_MR: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MW: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_WBL: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_EXR: ALUSrcA = 1'b1;
        S_WBR: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_EXI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (Opcode)
            OP_ORI:  ALUOp = 3'b001;
            OP_LUI:  ALUOp = 3'b100;
            default: begin
              ALUOp = 3'b010;
              ExtOp = 1'b1;
            end
          endcase
        end
        S_WBI: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BR: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b110;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          ALUOp      = 3'b111;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = rst ? '0 : state_q;
  assign illegal = illegal_q & ~rst;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM that sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) over 2–5 states per instruction. It decodes the IR opcode field and supports the same instruction set and ALUOp encoding as the single-cycle decoder. It drives all datapath enables and muxes, and waits on a memory-ready handshake.

Parameters:
ST_W, 4, state register width (12 states used)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
Opcode  in  6  IR[31:26]; stable from ID onward
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero (BEQ)
IorD  out  1  0=PC, 1=ALUOut as memory address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  1=MDR, 0=ALUOut to register file
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
ALUOp  out  3  000 R(funct), 010 add, 001 or, 100 lui, 110 sub, 111 jump
ExtOp  out  1  1=sign, 0=zero extend
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse on instruction retire
illegal  out  1  sticky unsupported-opcode flag
state  out  ST_W  current state (debug)

Behaviour:
- Reset: state<=IF (0), illegal<=0. While rst=1, every control output is forced to 0; state reads 0.
- Outputs are decoded from state (Moore), except PCWrite, IRWrite, instr_done in MW, and the wait transitions, which are qualified by mem_ready. Every output not listed for a state is 0.
- IF(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00. If mem_ready=0, hold IF and keep MemRead asserted. If mem_ready=1, PCWrite=IRWrite=1 and go to ID.
- ID(1): ALUSrcA=0, ALUSrcB=11, ALUOp=010, ExtOp=1 (branch target into ALUOut). Dispatch on Opcode:
  - 000000 -> EXR
  - 001000, 001001, 001101, 001111 -> EXI
  - 100011, 101011 -> MA
  - 000100 -> BR
  - 000010 -> JMP
  - any other opcode -> IF with illegal<=1; no PC, register or memory write; no instr_done.
- MA(2): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=010. LW -> MR; SW -> MW.
- MR(3): MemRead=1, IorD=1. Hold until mem_ready, then -> WBL.
- MW(4): MemWrite=1, IorD=1. Hold until mem_ready. On mem_ready: instr_done=1 and -> IF.
- WBL(5): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. -> IF.
- EXR(6): ALUSrcA=1, ALUSrcB=00, ALUOp=000. -> WBR.
- WBR(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. -> IF.
- EXI(8): ALUSrcA=1, ALUSrcB=10. ALUOp/ExtOp by opcode: 001000 ADDI = 010/1; 001001 ADDIU = 010/1; 001101 ORI = 001/0; 001111 LUI = 100/0. -> WBI.
- WBI(9): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. -> IF.
- BR(10): ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCWriteCond=1, PCSource=01, instr_done=1. -> IF.
- JMP(11): PCWrite=1, PCSource=10, ALUOp=111, instr_done=1. -> IF.
- Encodings 12–15 are unreachable. If entered, go to IF with all outputs 0.
- Latency with no wait states: R/I-type 4, LW 5, SW 4, BEQ 3, J 3, illegal 2 cycles. Each mem_ready=0 cycle in IF/MR/MW adds one cycle.
- mem_ready is ignored outside IF/MR/MW.
- rst asserted in any state, including mid-wait: next state IF, the pending access is abandoned, and no write enable is asserted in the reset cycle.
- illegal is cleared only by rst.

Test Plan:
- Reset then release with mem_ready=1 -> first cycle state=0, MemRead=1, PCWrite=IRWrite=1; all outputs 0 while rst=1.
- Opcode=000000, mem_ready=1 -> states 0,1,6,7,0. ALUOp=000 in EXR; RegWrite=RegDst=instr_done=1 in WBR.
- Opcode=100011 with mem_ready low for 2 cycles in MR -> states 0,1,2,3,3,3,5,0. MemRead=IorD=1 throughout MR; WBL has MemtoReg=RegWrite=1.
- Opcode=000100 -> states 0,1,10,0 with PCWriteCond=1, PCSource=01, ALUOp=110. Opcode=000010 -> states 0,1,11,0 with PCWrite=1, PCSource=10.
- Opcode=001101 -> EXI shows ALUOp=001, ExtOp=0. Opcode=001000 -> EXI shows ALUOp=010, ExtOp=1.
- Opcode=111111 -> states 0,1,0; illegal=1 and stays 1 through a following R-type; no RegWrite/MemWrite/instr_done for the bad op. rst during MW with mem_ready=0 -> state 0 next cycle, MemWrite=0, illegal=0.
